// File: rtl/mr_wb_arb.sv
// mr_wb_arb: shares the register-file write port between ALU and load-return producers; `WB_ARB_RR_EN selects round-robin contention, else mem wins.
// Latency: one cycle from a real grant to wb_valid/wb_reg/wb_val/wb_src.
// Backpressure: the contention loser sees ready=0 and holds its request; the write port itself never stalls.
module mr_wb_arb #(
   parameter int XLEN        = 32,
   parameter int REGSEL_BITS = 5,
   parameter int CNT_BITS    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_valid,
   output logic                   alu_ready,
   input  logic [REGSEL_BITS-1:0] alu_reg,
   input  logic [XLEN-1:0]        alu_val,
   input  logic                   mem_valid,
   output logic                   mem_ready,
   input  logic [REGSEL_BITS-1:0] mem_reg,
   input  logic [XLEN-1:0]        mem_val,
   output logic                   wb_valid,
   output logic [REGSEL_BITS-1:0] wb_reg,
   output logic [XLEN-1:0]        wb_val,
   output logic                   wb_src,
   output logic [CNT_BITS-1:0]    conflict_cnt
);

   typedef struct packed {
      logic                   src;
      logic [REGSEL_BITS-1:0] rd;
      logic [XLEN-1:0]        val;
   } wb_t;

   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   logic                alu_real;
   logic                alu_null;
   logic                mem_real;
   logic                mem_null;
   logic                contention;
   logic                mem_wins;
   logic                grant_alu;
   logic                grant_mem;
   logic                grant_any;
   logic                last_grant;
   logic                wb_vld_q;
   wb_t                 wb_q;
   wb_t                 wb_d;
   logic [CNT_BITS-1:0] cnt_q;

   // Writes to x0 are architecturally dropped, so they never compete for the port.
   always_comb begin
      alu_real   = alu_valid && (alu_reg != '0);
      alu_null   = alu_valid && (alu_reg == '0);
      mem_real   = mem_valid && (mem_reg != '0);
      mem_null   = mem_valid && (mem_reg == '0);
      contention = alu_real && mem_real;
`ifdef WB_ARB_RR_EN
      mem_wins   = (last_grant == SRC_ALU);
`else
      mem_wins   = 1'b1;
`endif
      grant_alu  = !rst && alu_real && (!mem_real || !mem_wins);
      grant_mem  = !rst && mem_real && (!alu_real || mem_wins);
      grant_any  = grant_alu || grant_mem;
      alu_ready  = !rst && (alu_null || grant_alu);
      mem_ready  = !rst && (mem_null || grant_mem);
   end

   always_comb begin
      wb_d = wb_q;
      if (grant_mem) begin
         wb_d.src = SRC_MEM;
         wb_d.rd  = mem_reg;
         wb_d.val = mem_val;
      end else if (grant_alu) begin
         wb_d.src = SRC_ALU;
         wb_d.rd  = alu_reg;
         wb_d.val = alu_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_vld_q   <= 1'b0;
         wb_q       <= '0;
         last_grant <= SRC_MEM;
         cnt_q      <= '0;
      end else begin
         wb_vld_q   <= grant_any;
         wb_q       <= wb_d;
         last_grant <= grant_any ? grant_mem : last_grant;
         if (contention && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_BITS'(1);
         end
      end
   end

   assign wb_valid     = wb_vld_q;
   assign wb_reg       = wb_q.rd;
   assign wb_val       = wb_q.val;
   assign wb_src       = wb_q.src;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mr_wb_arb.sv
// tb_mr_wb_arb: table vectors plus hand sequences for contention, saturation and reset; expected writes go through a scoreboard queue.
module tb_mr_wb_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, mem_valid;
   logic        alu_ready, mem_ready;
   logic [4:0]  alu_reg, mem_reg;
   logic [31:0] alu_val, mem_val;
   logic        wb_valid, wb_src;
   logic [4:0]  wb_reg;
   logic [31:0] wb_val;
   logic [3:0]  conflict_cnt;

   mr_wb_arb #(.XLEN(32), .REGSEL_BITS(5), .CNT_BITS(4)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_val(alu_val),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_val(mem_val),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_val(wb_val), .wb_src(wb_src),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        src;
      logic [4:0]  rd;
      logic [31:0] val;
   } wr_t;

   typedef struct {
      logic        av;
      logic [4:0]  ar;
      logic [31:0] aval;
      logic        mv;
      logic [4:0]  mr;
      logic [31:0] mval;
      logic        exp_ar;
      logic        exp_mr;
      string       name;
   } vec_t;

   wr_t  exp_q[$];
   wr_t  last_wr;
   vec_t vecs[10];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] aval,
                        input logic mv, input logic [4:0] mr, input logic [31:0] mval);
      alu_valid = av; alu_reg = ar; alu_val = aval;
      mem_valid = mv; mem_reg = mr; mem_val = mval;
   endtask

   // Checks readies for the current inputs, predicts the write, clocks once, then checks the port.
   task automatic step(input string name, input logic exp_ar, input logic exp_mr);
      int  n_exp;
      wr_t e;
      n_exp = 0;
      #1;
      chk({name, " alu_ready"}, 64'(alu_ready), 64'(exp_ar));
      chk({name, " mem_ready"}, 64'(mem_ready), 64'(exp_mr));
      if (exp_ar && alu_valid && alu_reg != 5'd0) begin
         exp_q.push_back('{1'b0, alu_reg, alu_val});
         n_exp++;
      end
      if (exp_mr && mem_valid && mem_reg != 5'd0) begin
         exp_q.push_back('{1'b1, mem_reg, mem_val});
         n_exp++;
      end
      @(posedge clk);
      #1;
      if (n_exp > 0) begin
         chk({name, " wb_valid"}, 64'(wb_valid), 64'd1);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: queue empty", name);
         end else begin
            e = exp_q.pop_front();
            chk({name, " wb_reg"}, 64'(wb_reg), 64'(e.rd));
            chk({name, " wb_val"}, 64'(wb_val), 64'(e.val));
            chk({name, " wb_src"}, 64'(wb_src), 64'(e.src));
            last_wr = e;
         end
      end else begin
         chk({name, " wb_valid"}, 64'(wb_valid), 64'd0);
         chk({name, " wb_reg hold"}, 64'(wb_reg), 64'(last_wr.rd));
         chk({name, " wb_val hold"}, 64'(wb_val), 64'(last_wr.val));
         chk({name, " wb_src hold"}, 64'(wb_src), 64'(last_wr.src));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      last_wr = '0;
      exp_q.delete();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      step("reset_a", 1'b0, 1'b0);
      step("reset_b", 1'b0, 1'b0);
      chk("reset conflict_cnt", 64'(conflict_cnt), 64'd0);
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   initial begin
      logic alu_turn;
      vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 1'b0, "idle"};
      vecs[1] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, "alu_single"};
      vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 1'b0, "after_single"};
      vecs[3] = '{1'b1, 5'd0,  32'h99,       1'b1, 5'd7,  32'h12, 1'b1, 1'b1, "x0_plus_mem"};
      vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55, 1'b0, 1'b1, "mem_null"};
      vecs[5] = '{1'b1, 5'd0,  32'h66,       1'b1, 5'd0,  32'h77, 1'b1, 1'b1, "both_null"};
      vecs[6] = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b1, 5'd0,  32'h88, 1'b1, 1'b1, "alu_plus_null"};
      vecs[7] = '{1'b1, 5'd10, 32'h00000001, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, "b2b_alu"};
      vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'h2,  1'b0, 1'b1, "b2b_mem"};
      vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 1'b0, "idle_end"};

      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      do_reset();

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].av, vecs[i].ar, vecs[i].aval, vecs[i].mv, vecs[i].mr, vecs[i].mval);
         step(vecs[i].name, vecs[i].exp_ar, vecs[i].exp_mr);
      end
      chk("no_contention conflict_cnt", 64'(conflict_cnt), 64'd0);

      // First contention after reset: ALU wins under round-robin, mem under fixed priority.
      do_reset();
      drive(1'b1, 5'd3, 32'h333, 1'b1, 5'd4, 32'h444);
`ifdef WB_ARB_RR_EN
      step("contend_1st", 1'b1, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h444);
      step("contend_2nd", 1'b0, 1'b1);
`else
      step("contend_1st", 1'b0, 1'b1);
      drive(1'b1, 5'd3, 32'h333, 1'b0, 5'd0, 32'h0);
      step("contend_2nd", 1'b1, 1'b0);
`endif
      chk("contend conflict_cnt", 64'(conflict_cnt), 64'd1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step("contend_idle", 1'b0, 1'b0);

      // Sustained contention: count climbs from 1 and must pin at 0xF.
      alu_turn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 5'd3, 32'h1000 + i, 1'b1, 5'd4, 32'h2000 + i);
`ifdef WB_ARB_RR_EN
         step("sat", alu_turn, !alu_turn);
         alu_turn = !alu_turn;
`else
         step("sat", 1'b0, 1'b1);
`endif
         if (i == 9) chk("sat mid conflict_cnt", 64'(conflict_cnt), 64'd11);
      end
      chk("sat conflict_cnt", 64'(conflict_cnt), 64'hF);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step("sat_idle", 1'b0, 1'b0);

      // Reset arriving right after a grant and while contention is offered.
      drive(1'b1, 5'd12, 32'h77, 1'b0, 5'd0, 32'h0);
      step("pre_rst_grant", 1'b1, 1'b0);
      rst = 1'b1;
      last_wr = '0;
      drive(1'b1, 5'd3, 32'h333, 1'b1, 5'd4, 32'h444);
      step("mid_rst_a", 1'b0, 1'b0);
      chk("mid_rst conflict_cnt", 64'(conflict_cnt), 64'd0);
      step("mid_rst_b", 1'b0, 1'b0);
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h444);
      step("post_rst_mem", 1'b0, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step("post_rst_idle", 1'b0, 1'b0);
      chk("final scoreboard empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
